mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Memory-side responder for the pipeline's split instruction (port a) and data (port b) memory interfaces. It accepts read/write requests on both ports, arbitrates them onto a single physical memory port (pmem) with variable latency, and returns a one-cycle `mem_resp_x` pulse with registered read data to the requesting port. It sits between the pipelined LC-3b datapath and the cache/physical memory.

## Interface
Parameters:
- `DATA_PRIORITY`, default 1. 1: port b always wins simultaneous requests. 0: alternate grant on simultaneous requests, starting with b after reset.

Ports (`lc3b_word` = 16 bits):
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_read_a`, `mem_write_a`  in  1 each  port a request strobes.
- `mem_wmask_a`  in  2  byte mask for port a.
- `mem_address_a`, `mem_wdata_a`  in  16 each  port a address and write data.
- `mem_resp_a`  out  1  one-cycle completion pulse for port a.
- `mem_rdata_a`  out  16  port a read data, valid while `mem_resp_a`=1.
- Port b: `mem_read_b`, `mem_write_b`, `mem_wmask_b`, `mem_address_b`, `mem_wdata_b`, `mem_resp_b`, `mem_rdata_b`, identical to port a.
- `pmem_read`, `pmem_write`  out  1 each  physical memory strobes.
- `pmem_wmask`  out  2  physical byte mask.
- `pmem_address`, `pmem_wdata`  out  16 each  physical address and write data.
- `pmem_resp`  in  1  physical completion, one cycle.
- `pmem_rdata`  in  16  physical read data, valid with `pmem_resp`.

## Operation
- A port requests when its read or write strobe is 1. Read and write together on one port: treated as a write, read ignored.
- FSM states:
  - IDLE
    - No request: stay in IDLE.
    - Request(s) present: choose a grant per `DATA_PRIORITY`.
    - Latch op, address, wdata and wmask of the granted port into internal registers.
    - Go to SERVE_A or SERVE_B.
    - In alternate mode, `last_grant` updates on each grant.
  - SERVE_A / SERVE_B
    - Drive pmem from the latched registers only; `pmem_read`/`pmem_write` stay asserted continuously.
    - Requester inputs are not re-sampled, so requester changes mid-transaction have no effect.
    - On `pmem_resp`=1: if op=read, capture `pmem_rdata` into that port's rdata register. Go to RESP_A or RESP_B.
  - RESP_A / RESP_B
    - Assert that port's `mem_resp_x` for exactly this cycle; pmem strobes are 0.
    - Next state is always IDLE.
- `mem_rdata_x` holds the last read value captured for that port. Write completions leave it unchanged.
- The non-granted port keeps waiting; it is served on a later IDLE pass. No request is ever dropped.
- `pmem_resp` in IDLE or RESP states is ignored.

## Timing
- Reset (asynchronous, active-low):
  - State goes to IDLE.
  - `mem_resp_a/b`=0, `mem_rdata_a/b`=0.
  - All pmem outputs =0.
  - `last_grant`=a, so b is granted first.
  - Effect is immediate, without a clock edge. An in-flight pmem transaction is abandoned; its late `pmem_resp` is ignored.
- Latency: request visible at edge 0 -> pmem strobe from cycle 1 -> `pmem_resp` in cycle k -> `mem_resp_x` in cycle k+1 -> IDLE in cycle k+2. Minimum is 3 cycles (k=1).
- A requester holds its strobes and data until it sees `mem_resp_x`. It may drop or change them in the cycle after.
- A request held through RESP is re-sampled in IDLE, so back-to-back requests are possible. Throughput is at most one transaction per k+2 cycles.
- `mem_resp_a` and `mem_resp_b` are never high in the same cycle.
- All outputs are registered or decoded directly from state and registers. There is no combinational path from inputs to outputs.

## Structure
- Add to package `lc3b_types`:
  - `lc3b_mem_wmask` (2-bit typedef).
  - `lc3b_arb_state` enum {IDLE, SERVE_A, SERVE_B, RESP_A, RESP_B}.
- One sub-module: `arb_select`, a combinational grant decision. Inputs: `req_a`, `req_b`, `last_grant`, `DATA_PRIORITY`. Outputs: `grant_a`, `grant_b`.
- The FSM, latch registers and rdata registers live in `mem_port_arbiter`.

## Test plan
- Single read, port a, address 0x0040, pmem returns 0x1234 after 2 cycles -> `pmem_read`=1 with `pmem_address`=0x0040 for 2 cycles; `mem_resp_a` high 1 cycle with `mem_rdata_a`=0x1234; `mem_resp_b` stays 0.
- Write, port b, address 0x0100, wdata 0xBEEF, wmask 2'b01 -> `pmem_write`=1 with matching address, data and mask; `mem_resp_b` pulses once; `mem_rdata_b` unchanged.
- Simultaneous read on a (0x0010) and read on b (0x0020), `DATA_PRIORITY`=1 -> b served first, then a; two `mem_resp` pulses at distinct cycles.
- Same stimulus with `DATA_PRIORITY`=0, held requests repeated 4 times -> grants alternate b, a, b, a.
- `rst_n` dropped while in SERVE_B, then `pmem_resp` arrives after release -> pmem strobes fall immediately; no `mem_resp_b`; FSM stays in IDLE until a new request.
- Port a asserts read and write together with wdata 0x5555 -> `pmem_write`=1, `pmem_read`=0; `mem_resp_a` pulses once.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-interface types used by the port arbiter.
package lc3b_types;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned WMASK_W = 2;

  typedef logic [WORD_W-1:0]  lc3b_word;
  typedef logic [WMASK_W-1:0] lc3b_mem_wmask;

  typedef enum logic [2:0] {
    IDLE,
    SERVE_A,
    SERVE_B,
    RESP_A,
    RESP_B
  } lc3b_arb_state;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } lc3b_port;

  // One latched requester transaction as presented to pmem.
  typedef struct packed {
    logic          write;
    lc3b_word      address;
    lc3b_word      wdata;
    lc3b_mem_wmask wmask;
  } lc3b_mem_req;

endpackage

// File: rtl/arb_select.sv
// Grant decision between instruction (a) and data (b) requesters.
module arb_select
  import lc3b_types::*;
#(
  parameter int unsigned DATA_PRIORITY = 1
) (
  input  logic     req_a,
  input  logic     req_b,
  input  lc3b_port last_grant,
  output logic     grant_a,
  output logic     grant_b
);

  // Single requester wins outright; a tie goes to b or to whoever was not last served.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (req_a && req_b) begin
      if ((DATA_PRIORITY != 0) || (last_grant == GRANT_A)) begin
        grant_b = 1'b1;
      end else begin
        grant_a = 1'b1;
      end
    end else begin
      grant_a = req_a;
      grant_b = req_b;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates split instruction/data memory ports onto one physical memory port.
module mem_port_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned DATA_PRIORITY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_read_a,
  input  logic          mem_write_a,
  input  lc3b_mem_wmask mem_wmask_a,
  input  lc3b_word      mem_address_a,
  input  lc3b_word      mem_wdata_a,
  output logic          mem_resp_a,
  output lc3b_word      mem_rdata_a,
  input  logic          mem_read_b,
  input  logic          mem_write_b,
  input  lc3b_mem_wmask mem_wmask_b,
  input  lc3b_word      mem_address_b,
  input  lc3b_word      mem_wdata_b,
  output logic          mem_resp_b,
  output lc3b_word      mem_rdata_b,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_mem_wmask pmem_wmask,
  output lc3b_word      pmem_address,
  output lc3b_word      pmem_wdata,
  input  logic          pmem_resp,
  input  lc3b_word      pmem_rdata
);

  lc3b_arb_state r_state;
  lc3b_arb_state w_next_state;
  lc3b_port      r_last_grant;
  lc3b_mem_req   r_req;
  lc3b_word      r_rdata_a;
  lc3b_word      r_rdata_b;
  logic          w_req_a;
  logic          w_req_b;
  logic          w_grant_a;
  logic          w_grant_b;
  logic          w_serving;

  assign w_req_a = mem_read_a | mem_write_a;
  assign w_req_b = mem_read_b | mem_write_b;

  arb_select #(
    .DATA_PRIORITY(DATA_PRIORITY)
  ) u_arb_select (
    .req_a     (w_req_a),
    .req_b     (w_req_b),
    .last_grant(r_last_grant),
    .grant_a   (w_grant_a),
    .grant_b   (w_grant_b)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: IDLE -> SERVE_x -> (pmem_resp) -> RESP_x -> IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_b) begin
          w_next_state = SERVE_B;
        end else if (w_grant_a) begin
          w_next_state = SERVE_A;
        end
      end
      SERVE_A: if (pmem_resp) w_next_state = RESP_A;
      SERVE_B: if (pmem_resp) w_next_state = RESP_B;
      RESP_A:  w_next_state = IDLE;
      RESP_B:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Latch the granted request in IDLE; write wins over read on the same port.
  // last_grant only influences ties when alternation is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req        <= '0;
      r_last_grant <= GRANT_A;
    end else if (r_state == IDLE) begin
      if (w_grant_b) begin
        r_req        <= '{write: mem_write_b, address: mem_address_b,
                          wdata: mem_wdata_b, wmask: mem_wmask_b};
        r_last_grant <= GRANT_B;
      end else if (w_grant_a) begin
        r_req        <= '{write: mem_write_a, address: mem_address_a,
                          wdata: mem_wdata_a, wmask: mem_wmask_a};
        r_last_grant <= GRANT_A;
      end
    end
  end

  // Capture read data for the port being served; writes leave rdata untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata_a <= '0;
      r_rdata_b <= '0;
    end else if (pmem_resp && !r_req.write) begin
      if (r_state == SERVE_A) r_rdata_a <= pmem_rdata;
      if (r_state == SERVE_B) r_rdata_b <= pmem_rdata;
    end
  end

  // Outputs decoded from state and latched registers only.
  always_comb begin
    w_serving    = (r_state == SERVE_A) || (r_state == SERVE_B);
    pmem_read    = w_serving && !r_req.write;
    pmem_write   = w_serving && r_req.write;
    pmem_address = r_req.address;
    pmem_wdata   = r_req.wdata;
    pmem_wmask   = r_req.wmask;
    mem_resp_a   = (r_state == RESP_A);
    mem_resp_b   = (r_state == RESP_B);
    mem_rdata_a  = r_rdata_a;
    mem_rdata_b  = r_rdata_b;
  end

endmodule
